// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//   Closed-loop stimulus/response checker for a 2-input logic gate.
//   On START, it drives the four vectors {A,B} = 00, 01, 10, 11 in turn.
//   Each vector is held for HOLD_CYCLES cycles. At the last edge of each
//   hold, Y is compared with the captured truth table.
//
// Ports
//   CLK      in   clock, rising edge
//   RST_N    in   synchronous active-low reset
//   START    in   request a run (accepted only when idle)
//   TT[3:0]  in   expected truth table, bit i = Y for vector i = {A,B}
//   Y        in   gate-under-test output
//   A, B     out  gate inputs (A = MSB of vector index)
//   BUSY     out  run in progress
//   DONE     out  one-cycle completion pulse
//   PASS     out  last completed run had no mismatches
//   ERR_MAP  out  per-vector mismatch flags (live during a run)
//   ERR_CNT  out  number of mismatching vectors (live during a run)
module gate_truth_checker #(
  parameter int HOLD_CYCLES = 100
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] TT,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_MAP,
  output logic [2:0] ERR_CNT
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tt_q, tt_d;
  logic [1:0]    ab_q, ab_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [3:0]    err_map_q, err_map_d;
  logic [2:0]    err_cnt_q, err_cnt_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tt_d      = tt_q;
    ab_d      = ab_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_map_d = err_map_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_HOLD;
          tt_d      = TT;
          err_map_d = 4'b0000;
          err_cnt_d = 3'd0;
          pass_d    = 1'b0;
          idx_d     = 2'd0;
          cnt_d     = '0;
          ab_d      = 2'b00;
          busy_d    = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          // Sample edge: score the vector that has been held the full time.
          if (Y != tt_q[idx_q]) begin
            err_map_d[idx_q] = 1'b1;
            err_cnt_d        = err_cnt_q + 3'd1;
          end
          cnt_d = '0;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            ab_d  = idx_q + 2'd1;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        // err_cnt_q already includes the vector-3 result from the previous edge.
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ab_d    = 2'b00;
        pass_d  = (err_cnt_q == 3'd0);
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      tt_q      <= 4'b0000;
      ab_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_map_q <= 4'b0000;
      err_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tt_q      <= tt_d;
      ab_q      <= ab_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_map_q <= err_map_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign A       = ab_q[1];
  assign B       = ab_q[0];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_MAP = err_map_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three checkers with hold times 4, 2 and 1,
// each closed around a modelled gate whose behaviour is a 4-bit table gt.
// Expected results come from gt ^ tt (mismatch vector) and its popcount.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start   [3];
  logic [3:0] tt      [3];
  logic [3:0] gt      [3];
  logic       y       [3];
  logic       a       [3];
  logic       b       [3];
  logic       busy    [3];
  logic       done    [3];
  logic       pass    [3];
  logic [3:0] err_map [3];
  logic [2:0] err_cnt [3];

  int hv [3] = '{4, 2, 1};
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] NAND_T = 4'b0111;
  localparam logic [3:0] AND_T  = 4'b1000;
  localparam logic [3:0] ONE_T  = 4'b1111;

  assign y[0] = gt[0][{a[0], b[0]}];
  assign y[1] = gt[1][{a[1], b[1]}];
  assign y[2] = gt[2][{a[2], b[2]}];

  gate_truth_checker #(.HOLD_CYCLES(4)) u0 (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .TT(tt[0]), .Y(y[0]),
    .A(a[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
    .ERR_MAP(err_map[0]), .ERR_CNT(err_cnt[0]));
  gate_truth_checker #(.HOLD_CYCLES(2)) u1 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .TT(tt[1]), .Y(y[1]),
    .A(a[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
    .ERR_MAP(err_map[1]), .ERR_CNT(err_cnt[1]));
  gate_truth_checker #(.HOLD_CYCLES(1)) u2 (
    .CLK(clk), .RST_N(rst_n), .START(start[2]), .TT(tt[2]), .Y(y[2]),
    .A(a[2]), .B(b[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]),
    .ERR_MAP(err_map[2]), .ERR_CNT(err_cnt[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Mismatches among vectors 0..n-1.
  function automatic logic [3:0] mask_below(input logic [3:0] m, input int n);
    logic [3:0] r = 4'b0000;
    for (int j = 0; j < n; j++) r[j] = m[j];
    return r;
  endfunction

  function automatic logic [7:0] pc_below(input logic [3:0] m, input int n);
    logic [7:0] c = 8'd0;
    for (int j = 0; j < n; j++) if (m[j]) c++;
    return c;
  endfunction

  task automatic chk_reset(input int u);
    chk("rst_a",    a[u],       1'b0);
    chk("rst_b",    b[u],       1'b0);
    chk("rst_busy", busy[u],    1'b0);
    chk("rst_done", done[u],    1'b0);
    chk("rst_pass", pass[u],    1'b0);
    chk("rst_map",  err_map[u], 4'b0000);
    chk("rst_cnt",  err_cnt[u], 3'd0);
  endtask

  // Called at a negedge. Raises START for the next edge (k) and follows the
  // run to the negedge after the DONE edge (k+4H+1). If glitch >= 0, a
  // second START with a corrupted TT is raised at that step of the run.
  task automatic do_run(input int u, input logic [3:0] g, input logic [3:0] t, input int glitch);
    int h = hv[u];
    logic [3:0] mm = g ^ t;
    gt[u] = g; tt[u] = t; start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < h; c++) begin
        chk("busy", busy[u], 1'b1);
        chk("done_low", done[u], 1'b0);
        chk("ab", {a[u], b[u]}, 8'(i));
        chk("cnt_live", err_cnt[u], pc_below(mm, i));
        chk("map_live", err_map[u], mask_below(mm, i));
        if (i * h + c == glitch) begin
          start[u] = 1'b1; tt[u] = ~t;
        end else begin
          start[u] = 1'b0; tt[u] = t;
        end
        @(negedge clk);
      end
    end
    start[u] = 1'b0; tt[u] = t;
    chk("fin_busy", busy[u], 1'b1);
    chk("fin_done", done[u], 1'b0);
    chk("fin_ab", {a[u], b[u]}, 2'b11);
    chk("fin_cnt", err_cnt[u], pc_below(mm, 4));
    @(negedge clk);
    chk("done", done[u], 1'b1);
    chk("done_busy", busy[u], 1'b0);
    chk("done_ab", {a[u], b[u]}, 2'b00);
    chk("pass", pass[u], (mm == 4'b0000));
    chk("map", err_map[u], mm);
    chk("cnt", err_cnt[u], pc_below(mm, 4));
  endtask

  task automatic post_idle(input int u);
    logic [3:0] mm = gt[u] ^ tt[u];
    @(negedge clk);
    chk("done_clr", done[u], 1'b0);
    chk("idle_busy", busy[u], 1'b0);
    chk("hold_pass", pass[u], (mm == 4'b0000));
    chk("hold_map", err_map[u], mm);
    chk("hold_cnt", err_cnt[u], pc_below(mm, 4));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b0; tt[u] = 4'b0000; gt[u] = NAND_T;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 3; u++) chk_reset(u);

    // NAND, H=4: clean pass.
    do_run(0, NAND_T, NAND_T, -1); post_idle(0);
    // AND against NAND table: every vector fails.
    do_run(0, AND_T, NAND_T, -1); post_idle(0);
    // Y stuck at 1, H=2: only vector 3 fails.
    do_run(1, ONE_T, NAND_T, -1); post_idle(1);
    // START re-pulsed at edge k+5 (with garbage TT) is ignored.
    do_run(0, NAND_T, NAND_T, 4); post_idle(0);

    // Reset during vector 2 with an AND gate (partial map is nonzero).
    gt[0] = AND_T; tt[0] = NAND_T; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_map", err_map[0], 4'b0011);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset(0);
    for (int c = 0; c < 12; c++) begin
      chk("post_rst_done", done[0], 1'b0);
      chk("post_rst_busy", busy[0], 1'b0);
      @(negedge clk);
    end
    do_run(0, NAND_T, NAND_T, -1); post_idle(0);

    // H=1 back-to-back runs; the middle one fails so clearing is visible.
    do_run(2, NAND_T, NAND_T, -1);
    do_run(2, AND_T, NAND_T, -1);
    do_run(2, NAND_T, NAND_T, -1);
    post_idle(2);

    // Random gates, tables, units and ignored-START positions.
    for (int r = 0; r < 10; r++) begin
      int u = int'($urandom_range(0, 2));
      logic [3:0] g = 4'($urandom);
      logic [3:0] t = 4'($urandom);
      int gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * hv[u] - 1)) : -1;
      do_run(u, g, t, gl);
      post_idle(u);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus/response engine for 2-input logic gates. On START it drives the four input vectors 00, 01, 10, 11 onto a gate under test, holding each for a fixed number of cycles. At the end of each hold it samples the gate output and compares it against a 4-bit expected truth table. It reports per-vector mismatches, a mismatch count and PASS. It is the hardware counterpart of the gate stimulus benches: it replaces the open-loop driver with a closed-loop driver and checker usable in simulation or on board.

## Interface
Parameters:
- HOLD_CYCLES, default 100: cycles each vector is driven before Y is sampled; legal range ≥ 1.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset, sampled on rising CLK.
- START  in  1  request a test run; accepted only in IDLE.
- TT  in  4  expected truth table; bit i = expected Y for vector i = {A,B}; captured when START is accepted (NAND = 4'b0111).
- Y  in  1  output of gate under test (combinational from A,B).
- A  out  1  gate input A (MSB of vector index).
- B  out  1  gate input B (LSB of vector index).
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse when a run completes.
- PASS  out  1  1 when the completed run had zero mismatches.
- ERR_MAP  out  4  bit i set when vector i mismatched.
- ERR_CNT  out  3  number of mismatching vectors, 0..4.

## Operation
- Reset values: A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_MAP=0, ERR_CNT=0; FSM in IDLE, vector index 0, hold counter 0.
- FSM states: IDLE, HOLD, FINISH.
- IDLE → HOLD on START=1:
  - Capture TT into tt_q; clear ERR_MAP, ERR_CNT and PASS.
  - Set index=0, drive {A,B}=00, set counter=0, BUSY=1.
- HOLD: counter increments each cycle. When counter==HOLD_CYCLES-1, that edge is the sample edge:
  - Compare Y against tt_q[index]. On mismatch, set ERR_MAP[index] and increment ERR_CNT.
  - If index<3: increment index, drive the next vector {A,B}=index+1, and reset counter to 0.
  - If index==3: go to FINISH.
- FINISH is entered and left in a single cycle. On the following edge:
  - DONE=1, BUSY=0, {A,B}=00.
  - PASS=1 if ERR_CNT==0 (including a mismatch on vector 3 counted at the previous edge).
  - Return to IDLE.
- DONE clears on the next edge.
- PASS, ERR_MAP and ERR_CNT hold their values until the next accepted START.
- ERR_MAP and ERR_CNT update live during a run, at each sample edge. PASS is meaningful only after DONE.
- START while BUSY (HOLD or FINISH) is ignored, with no effect on the run.
- START in the same cycle DONE is high is accepted, since the FSM is in IDLE.
- Counter width is $clog2(HOLD_CYCLES+1). The index is 2 bits and never wraps within a run.

## Timing
- START sampled high at edge k:
  - A, B, BUSY valid after edge k.
  - Vector i is driven from edge k+i·H to edge k+(i+1)·H, where H=HOLD_CYCLES.
  - Y for vector i is sampled at edge k+(i+1)·H.
- Final sample at edge k+4H. FINISH occupies the cycle after it.
- DONE high for one cycle, after edge k+4H+1. BUSY falls at the same edge.
- Total latency from START edge to DONE rising: 4H+1 cycles.
- With H=1, each vector is driven for exactly one cycle and sampled at the next edge.
- RST_N=0 at any edge, including mid-run, forces all reset values at that edge:
  - No DONE pulse; the partial ERR_MAP is discarded.
  - RST_N has priority over START.

## Test plan
- NAND gate as DUT, TT=4'b0111, H=4, START at edge 0 → A,B step 00/01/10/11 every 4 cycles; DONE pulses after edge 17; PASS=1, ERR_MAP=0000, ERR_CNT=0.
- AND gate as DUT, TT=4'b0111, H=4 → ERR_MAP=1111, ERR_CNT=4, PASS=0; ERR_CNT reads 1,2,3,4 after edges 4,8,12,16.
- Y tied to 1, TT=4'b0111, H=2 → ERR_MAP=1000, ERR_CNT=1, PASS=0; DONE after edge 9.
- START pulsed again at edge 5 during a run with H=4 → ignored; a single DONE after edge 17; results are those of the first run.
- RST_N low for one edge while vector 2 is driven → all outputs at reset values, A=B=0, no DONE. A following START runs a full clean sequence.
- H=1 with NAND DUT, START reasserted in the DONE cycle → two back-to-back runs, each 5 cycles START-to-DONE, both PASS=1. ERR_MAP is cleared at the second START.
